mlab_scfifo_sa: RTL

- Single-clock show-ahead FIFO on MLAB storage, parametrised in width, depth and target family.
- Successor to the dual-clock MLAB RAM primitive. Adds pointer management, occupancy count, almost-thresholds, flush and sticky error flags.
- Full 1-word/clk throughput despite the registered MLAB read.
- Used for shallow intra-domain buffering in datapath pipelines.

---
 rtl/mlab_fifo_pkg.sv | 20 ++
 rtl/generic_mlab_sc.sv | 88 ++++++++
 rtl/mlab_scfifo_sa.sv | 108 ++++++++++
 3 files changed

// File: rtl/mlab_fifo_pkg.sv
// Shared constants and sizing helpers for the MLAB-based single-clock FIFOs.
// Family names select the storage implementation inside generic_mlab_sc.
package mlab_fifo_pkg;

  localparam string FAMILY_AGILEX = "Agilex";
  localparam string FAMILY_S10    = "S10";
  localparam string FAMILY_OTHER  = "Other";

  localparam int DEFAULT_AE_THRESH = 2;

  // Occupancy must represent 0..depth inclusive, hence one bit above the address.
  function automatic int usedw_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int default_af_thresh(input int depth);
    return (depth > 4) ? (depth - 4) : depth;
  endfunction

endpackage

// File: rtl/generic_mlab_sc.sv
// Single-clock MLAB RAM: synchronous write, registered read with read enable.
// The read register doubles as the FIFO output stage.
module generic_mlab_sc
  import mlab_fifo_pkg::*;
#(
  parameter int    WIDTH      = 8,
  parameter int    ADDR_WIDTH = 5,
  parameter string FAMILY     = FAMILY_OTHER
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (FAMILY == FAMILY_S10) begin : g_s10
    (* ramstyle = "mlab" *) logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0]      wdata_r;
    logic [ADDR_WIDTH-1:0] waddr_r;
    logic                  we_r;
    logic [WIDTH-1:0]      rdata_r;

    // Registered write-input stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        we_r    <= 1'b0;
        waddr_r <= {ADDR_WIDTH{1'b0}};
        wdata_r <= {WIDTH{1'b0}};
      end else begin
        we_r    <= we;
        waddr_r <= waddr;
        wdata_r <= wdata;
      end
    end

    // Array write from the input stage
    always_ff @(posedge clk) begin
      if (we_r) mem_r[waddr_r] <= wdata_r;
    end

    // Registered read; a word still in the input stage is forwarded so it is
    // readable one cycle after its write, as with the other families.
    always_ff @(posedge clk) begin
      if (re) rdata_r <= (we_r && (waddr_r == raddr)) ? wdata_r : mem_r[raddr];
    end

    assign rdata = rdata_r;
  end else if (FAMILY == FAMILY_AGILEX) begin : g_agilex
    (* ramstyle = "mlab" *) logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Array write
    always_ff @(posedge clk) begin
      if (we) mem_r[waddr] <= wdata;
    end

    // Registered read, no reset on the primitive output register
    always_ff @(posedge clk) begin
      if (re) rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;
  end else begin : g_other
    (* ramstyle = "mlab" *) logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Array write
    always_ff @(posedge clk) begin
      if (we) mem_r[waddr] <= wdata;
    end

    // Registered read with reset so dout is defined from reset
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata_r <= {WIDTH{1'b0}};
      else if (re) rdata_r <= mem_r[raddr];
      else         rdata_r <= rdata_r;
    end

    assign rdata = rdata_r;
  end

endmodule

// File: rtl/mlab_scfifo_sa.sv
// Single-clock show-ahead FIFO on MLAB storage with count, thresholds, flush
// and sticky error flags. The RAM read register is the output stage.
module mlab_scfifo_sa
  import mlab_fifo_pkg::*;
#(
  parameter int    WIDTH      = 8,
  parameter int    ADDR_WIDTH = 5,
  parameter string FAMILY     = FAMILY_OTHER,
  parameter int    AF_THRESH  = default_af_thresh(1 << ADDR_WIDTH),
  parameter int    AE_THRESH  = DEFAULT_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  wreq,
  input  logic                  rreq,
  input  logic                  flush,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = usedw_width(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wptr_r, rptr_r;
  logic [CNT_W-1:0]      mem_cnt_r, usedw_s;
  logic                  out_valid_r, overflow_r, underflow_r;
  logic                  full_s, wa_s, ra_s, mem_re_s;
  logic [WIDTH-1:0]      rdata_s;

  // Accept qualification and prefetch decision; flush suppresses every request.
  always_comb begin
    usedw_s  = mem_cnt_r + CNT_W'(out_valid_r);
    full_s   = (usedw_s == CNT_W'(DEPTH));
    wa_s     = wreq & ~full_s & ~flush;
    ra_s     = rreq & out_valid_r & ~flush;
    mem_re_s = (mem_cnt_r != {CNT_W{1'b0}}) & (~out_valid_r | ra_s) & ~flush;
  end

  // Pointers, memory count and output-stage valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r      <= {ADDR_WIDTH{1'b0}};
      rptr_r      <= {ADDR_WIDTH{1'b0}};
      mem_cnt_r   <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (flush) begin
      wptr_r      <= {ADDR_WIDTH{1'b0}};
      rptr_r      <= {ADDR_WIDTH{1'b0}};
      mem_cnt_r   <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (wa_s) wptr_r <= wptr_r + PTR_ONE;
      if (mem_re_s) begin
        rptr_r      <= rptr_r + PTR_ONE;
        out_valid_r <= 1'b1;
      end else if (ra_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      mem_cnt_r <= mem_cnt_r + CNT_W'(wa_s) - CNT_W'(mem_re_s);
    end
  end

  // Sticky error flags, cleared only by reset; dropped requests under flush don't count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  | (wreq & full_s & ~flush);
      underflow_r <= underflow_r | (rreq & ~out_valid_r & ~flush);
    end
  end

  generic_mlab_sc #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FAMILY     (FAMILY)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wa_s),
    .waddr (wptr_r),
    .wdata (din),
    .re    (mem_re_s),
    .raddr (rptr_r),
    .rdata (rdata_s)
  );

  assign dout         = rdata_s;
  assign empty        = ~out_valid_r;
  assign full         = full_s;
  assign almost_full  = (usedw_s >= CNT_W'(AF_THRESH));
  assign almost_empty = (usedw_s <= CNT_W'(AE_THRESH));
  assign usedw        = usedw_s;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule
